// File: rtl/store_data_forward.sv
// Store-data forwarding: selects the freshest value of a store's source register from
// the retiring writeback or a short history of recently retired writes.
module store_data_forward #(
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int DEPTH = 3,
  localparam int SRCW = $clog2(DEPTH + 2)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_is_load,
  input  logic            st_valid,
  input  logic [REGW-1:0] st_rs2,
  input  logic [XLEN-1:0] st_data,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] mem_wdata,
  output logic            fwd_hit,
  output logic [SRCW-1:0] fwd_src,
  output logic [15:0]     fwd_load_cnt
);

  // History entry 0 is the youngest retired write.
  logic            hist_valid [DEPTH];
  logic [REGW-1:0] hist_rd    [DEPTH];
  logic [XLEN-1:0] hist_data  [DEPTH];
  logic            hist_load  [DEPTH];

  logic store_active;
  logic win_load;

  assign store_active = st_valid && (st_rs2 != '0);

  // Scan oldest to youngest so the youngest matching source overrides.
  always_comb begin
    mem_wdata = st_data;
    fwd_hit   = 1'b0;
    fwd_src   = '0;
    win_load  = 1'b0;
    if (store_active) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (hist_valid[k] && (hist_rd[k] == st_rs2)) begin
          mem_wdata = hist_data[k];
          fwd_hit   = 1'b1;
          fwd_src   = SRCW'(k + 2);
          win_load  = hist_load[k];
        end
      end
      if (wb_valid && (wb_rd == st_rs2)) begin
        mem_wdata = wb_data;
        fwd_hit   = 1'b1;
        fwd_src   = SRCW'(1);
        win_load  = wb_is_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) hist_valid[k] <= 1'b0;
      fwd_load_cnt <= '0;
    end else begin
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) hist_valid[k] <= 1'b0;
      end else if (!stall) begin
        for (int k = 1; k < DEPTH; k++) begin
          hist_valid[k] <= hist_valid[k-1];
          hist_rd[k]    <= hist_rd[k-1];
          hist_data[k]  <= hist_data[k-1];
          hist_load[k]  <= hist_load[k-1];
        end
        // Writes to x0 never become forwarding candidates.
        hist_valid[0] <= wb_valid && (wb_rd != '0);
        hist_rd[0]    <= wb_rd;
        hist_data[0]  <= wb_data;
        hist_load[0]  <= wb_is_load;
      end
      if (fwd_hit && !stall && win_load && (fwd_load_cnt != 16'hFFFF))
        fwd_load_cnt <= fwd_load_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_store_data_forward.sv
// Directed bench for store_data_forward: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_store_data_forward;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int DEPTH = 3;
  localparam int SRCW = $clog2(DEPTH + 2);
  localparam int W = XLEN + 1 + SRCW + 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb_valid;
  logic [REGW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_is_load;
  logic            st_valid;
  logic [REGW-1:0] st_rs2;
  logic [XLEN-1:0] st_data;
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] mem_wdata;
  logic            fwd_hit;
  logic [SRCW-1:0] fwd_src;
  logic [15:0]     fwd_load_cnt;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests_run = 0;
  int           tests_failed = 0;

  store_data_forward #(.XLEN(XLEN), .REGW(REGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_is_load(wb_is_load),
    .st_valid(st_valid), .st_rs2(st_rs2), .st_data(st_data),
    .stall(stall), .flush(flush),
    .mem_wdata(mem_wdata), .fwd_hit(fwd_hit), .fwd_src(fwd_src), .fwd_load_cnt(fwd_load_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: one call = one clock cycle of inputs; optional expectation for that cycle.
  task automatic step(input string nm, input logic rst,
                      input logic wv, input logic [REGW-1:0] wrd, input logic [XLEN-1:0] wdat,
                      input logic wld, input logic sv, input logic [REGW-1:0] srs2,
                      input logic [XLEN-1:0] sdat, input logic stl, input logic fl,
                      input logic chk, input logic [XLEN-1:0] e_wdata, input logic e_hit,
                      input logic [SRCW-1:0] e_src, input logic [15:0] e_cnt);
    @(posedge clk);
    #1;
    reset = rst; wb_valid = wv; wb_rd = wrd; wb_data = wdat; wb_is_load = wld;
    st_valid = sv; st_rs2 = srs2; st_data = sdat; stall = stl; flush = fl;
    if (chk) begin
      exp_q.push_back({e_wdata, e_hit, e_src, e_cnt});
      name_q.push_back(nm);
    end
  endtask

  // Scoreboard monitor: outputs settle well before the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = {mem_wdata, fwd_hit, fwd_src, fwd_load_cnt};
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s: got wdata=%h hit=%b src=%0d cnt=%h, expected wdata=%h hit=%b src=%0d cnt=%h",
                 nm, mem_wdata, fwd_hit, fwd_src, fwd_load_cnt,
                 e[W-1 -: XLEN], e[SRCW+16], e[SRCW+15 -: SRCW], e[15:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; wb_valid = 0; wb_rd = '0; wb_data = '0; wb_is_load = 0;
    st_valid = 0; st_rs2 = '0; st_data = '0; stall = 0; flush = 0;
    repeat (2) @(posedge clk);

    //   name          rst wv rd  wdata         ld sv rs2 sdata         stl fl chk e_wdata       hit src cnt
    step("reset_idle",  0, 0, 0, 32'h0,        0, 1, 1, 32'h100,      0, 0, 1, 32'h100,      0, 0, 16'd0);
    step("cur_wb_fwd",  0, 1, 5, 32'hDEADBEEF, 1, 1, 5, 32'h11111111, 0, 0, 1, 32'hDEADBEEF, 1, 1, 16'd0);
    step("hist0_load",  0, 0, 0, 32'h0,        0, 1, 5, 32'h22,       0, 0, 1, 32'hDEADBEEF, 1, 2, 16'd1);
    step("wr_x7_a",     0, 1, 7, 32'hA,        0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        0, 0, 16'd2);
    step("wr_x7_b",     0, 1, 7, 32'hB,        0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        0, 0, 16'd2);
    step("dup_young",   0, 0, 0, 32'h0,        0, 1, 7, 32'h33,       0, 0, 1, 32'hB,        1, 2, 16'd2);
    step("dup_hist1",   0, 0, 0, 32'h0,        0, 1, 7, 32'h33,       0, 0, 1, 32'hB,        1, 3, 16'd2);
    step("dup_hist2",   0, 0, 0, 32'h0,        0, 1, 7, 32'h33,       0, 0, 1, 32'hB,        1, 4, 16'd2);
    step("wr_x3",       0, 1, 3, 32'h55,       0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        0, 0, 16'd2);
    step("idle1",       0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 16'd0);
    step("idle2",       0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 16'd0);
    step("age_oldest",  0, 0, 0, 32'h0,        0, 1, 3, 32'h44,       0, 0, 1, 32'h55,       1, 4, 16'd2);
    step("age_dropped", 0, 0, 0, 32'h0,        0, 1, 3, 32'h44,       0, 0, 1, 32'h44,       0, 0, 16'd2);
    step("x0_wb_store", 0, 1, 0, 32'h99,       1, 1, 0, 32'h66,       0, 0, 1, 32'h66,       0, 0, 16'd2);
    step("x0_hist",     0, 0, 0, 32'h0,        0, 1, 0, 32'h67,       0, 0, 1, 32'h67,       0, 0, 16'd2);
    step("wr_x9",       0, 1, 9, 32'h77,       1, 0, 0, 32'h0,        0, 0, 1, 32'h0,        0, 0, 16'd2);
    step("stall_1",     0, 0, 0, 32'h0,        0, 1, 9, 32'h88,       1, 0, 1, 32'h77,       1, 2, 16'd2);
    step("stall_2",     0, 0, 0, 32'h0,        0, 1, 9, 32'h88,       1, 0, 1, 32'h77,       1, 2, 16'd2);
    step("stall_3",     0, 0, 0, 32'h0,        0, 1, 9, 32'h88,       1, 0, 1, 32'h77,       1, 2, 16'd2);
    step("unstall",     0, 0, 0, 32'h0,        0, 1, 9, 32'h88,       0, 0, 1, 32'h77,       1, 2, 16'd2);
    step("stall_wb",    0, 1, 10, 32'h1010,    0, 1, 10, 32'hAB,      1, 0, 1, 32'h1010,     1, 1, 16'd3);
    step("stall_nocap", 0, 0, 0, 32'h0,        0, 1, 10, 32'hAB,      0, 0, 1, 32'hAB,       0, 0, 16'd3);
    step("wr_x4",       0, 1, 4, 32'h1234,     0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        0, 0, 16'd3);
    step("flush_match", 0, 0, 0, 32'h0,        0, 1, 4, 32'hCC,       0, 1, 1, 32'h1234,     1, 2, 16'd3);
    step("post_flush",  0, 0, 0, 32'h0,        0, 1, 4, 32'hCC,       0, 0, 1, 32'hCC,       0, 0, 16'd3);
    step("flush_stall", 0, 1, 6, 32'h66,       0, 0, 0, 32'h0,        1, 1, 1, 32'h0,        0, 0, 16'd3);
    step("flush_drop",  0, 0, 0, 32'h0,        0, 1, 6, 32'hCD,       0, 0, 1, 32'hCD,       0, 0, 16'd3);

    // Drive the counter into saturation with repeated load-sourced forwards.
    for (int i = 0; i < 65540; i++)
      step("sat_fill",  0, 1, 8, 32'hF0F0,     1, 1, 8, 32'h0,        0, 0, 0, 32'h0,        0, 0, 16'd0);

    step("sat_hold",    0, 1, 8, 32'hF0F0,     1, 1, 8, 32'h0,        0, 0, 1, 32'hF0F0,     1, 1, 16'hFFFF);
    step("sat_flush",   0, 0, 0, 32'h0,        0, 1, 8, 32'h12,       0, 1, 1, 32'hF0F0,     1, 2, 16'hFFFF);
    step("cnt_kept",    0, 0, 0, 32'h0,        0, 1, 8, 32'h13,       0, 0, 1, 32'h13,       0, 0, 16'hFFFF);
    step("wr_x8",       0, 1, 8, 32'hABCD,     1, 0, 0, 32'h0,        0, 0, 1, 32'h0,        0, 0, 16'hFFFF);
    step("pre_reset",   1, 0, 0, 32'h0,        0, 1, 8, 32'h14,       1, 1, 1, 32'hABCD,     1, 2, 16'hFFFF);
    step("post_reset",  0, 0, 0, 32'h0,        0, 1, 8, 32'h15,       0, 0, 1, 32'h15,       0, 0, 16'd0);
    step("drain",       0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 16'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/store_data_forward.md
STORE_DATA_FORWARD -- requirements
Module: store_data_forward

Interface
REQ-001 Parameter XLEN, default 32, data width.
REQ-002 Parameter REGW, default 5, register-index width.
REQ-003 Parameter DEPTH, default 3, number of retired-writeback history entries (DEPTH >= 1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wb_valid  input  1  a register write retires this cycle.
REQ-007 wb_rd  input  REGW  destination register of retiring write.
REQ-008 wb_data  input  XLEN  value of retiring write.
REQ-009 wb_is_load  input  1  retiring value came from a memory read.
REQ-010 st_valid  input  1  store instruction present in MEM stage.
REQ-011 st_rs2  input  REGW  source register of store data.
REQ-012 st_data  input  XLEN  store data from the EX/MEM pipeline register.
REQ-013 stall  input  1  pipeline frozen this cycle.
REQ-014 flush  input  1  invalidate all history.
REQ-015 mem_wdata  output  XLEN  store data after forwarding selection.
REQ-016 fwd_hit  output  1  forwarding applied this cycle.
REQ-017 fwd_src  output  clog2(DEPTH+2)  0 = none, 1 = current writeback, k+2 = history entry k.
REQ-018 fwd_load_cnt  output  16  saturating count of load-sourced store forwards.

Function
REQ-019 History SHALL be DEPTH entries {valid, rd, data, is_load}; entry 0 is youngest.
REQ-020 Each cycle with stall=0 and flush=0, history SHALL shift (entry k -> k+1, entry DEPTH-1 dropped) and entry 0 SHALL load {wb_valid && wb_rd!=0, wb_rd, wb_data, wb_is_load}.
REQ-021 With stall=1 and flush=0, history SHALL hold unchanged; the retiring write is still visible through the current-writeback match path.
REQ-022 flush=1 SHALL clear all valid bits next cycle, regardless of stall or wb_valid; the same-cycle writeback is discarded from history.
REQ-023 A match candidate SHALL require st_valid=1, st_rs2!=0, candidate valid, and candidate rd==st_rs2.
REQ-024 Priority SHALL be current writeback (wb_valid && wb_rd==st_rs2) first, then history entry 0, 1, ... DEPTH-1; the youngest match wins on duplicate rd.
REQ-025 mem_wdata, fwd_hit and fwd_src SHALL be combinational from inputs and history (zero latency); on no match mem_wdata=st_data, fwd_hit=0, fwd_src=0.
REQ-026 flush=1 SHALL NOT suppress same-cycle matching against the pre-flush history.
REQ-027 fwd_load_cnt SHALL increment by 1 on a cycle with fwd_hit=1, stall=0, and a winning source with is_load=1 (wb_is_load for source 1), saturating at 0xFFFF.
REQ-028 flush SHALL NOT clear fwd_load_cnt.
REQ-029 With DEPTH=1, only fwd_src values 0..2 SHALL occur.

Reset
REQ-030 When reset=1 at a clock edge, all history valid bits SHALL clear and fwd_load_cnt SHALL become 0; reset SHALL take priority over flush, stall and the shift.
REQ-031 Immediately after reset, with no writeback, outputs SHALL be mem_wdata=st_data, fwd_hit=0, fwd_src=0.
REQ-032 Reset asserted mid-sequence SHALL discard all history; no forwarding from pre-reset writes.

Verification
REQ-033 Current-writeback forward: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF, wb_is_load=1; store st_rs2=5, st_data=0x11111111 in the same cycle -> mem_wdata=0xDEADBEEF, fwd_src=1, fwd_load_cnt 0->1.
REQ-034 History priority: write x7=0xA then x7=0xB on consecutive cycles, then a store st_rs2=7 one cycle later with no wb -> mem_wdata=0xB, fwd_src=2.
REQ-035 Aging: write x3=0x55, then DEPTH idle cycles, then a store st_rs2=3 -> with DEPTH=3 the entry has been dropped, giving fwd_hit=0 and mem_wdata=st_data; with one fewer idle cycle, fwd_src=4.
REQ-036 x0 and stall: writeback rd=0 data=0x99 then a store st_rs2=0 -> no hit. Write x9=0x77, then stall=1 for 3 cycles with a store st_rs2=9 -> fwd_src=2 throughout, and fwd_load_cnt unchanged during the stall.
REQ-037 Flush/reset: write x4=0x1234, then flush=1 with a store st_rs2=4 in the same cycle -> hit, fwd_src=2; next cycle the same store -> no hit. Preload fwd_load_cnt=0xFFFF, then a load-sourced forward -> stays 0xFFFF; then reset -> 0.
